// File: rtl/sid_pkg.sv
// Shared types and constants for the SID register file.
// Voice fields, register addresses and the bus-latch decay default.
package sid_pkg;

    localparam int DECAY_CYCLES_DEF = 8192;
    localparam int VOICE_STRIDE     = 7;

    typedef struct packed {
        logic [15:0] freq;
        logic [11:0] pw;
        logic        noise;
        logic        pulse;
        logic        saw;
        logic        triangle;
        logic        test;
        logic        ring;
        logic        sync;
        logic        gate;
        logic [3:0]  atk;
        logic [3:0]  dcy;
        logic [3:0]  stn;
        logic [3:0]  rls;
    } voice_regs_t;

    localparam logic [2:0] OFF_FREQ_LO = 3'd0;
    localparam logic [2:0] OFF_FREQ_HI = 3'd1;
    localparam logic [2:0] OFF_PW_LO   = 3'd2;
    localparam logic [2:0] OFF_PW_HI   = 3'd3;
    localparam logic [2:0] OFF_CTRL    = 3'd4;
    localparam logic [2:0] OFF_AD      = 3'd5;
    localparam logic [2:0] OFF_SR      = 3'd6;

    localparam logic [4:0] ADDR_FC_LO    = 5'h15;
    localparam logic [4:0] ADDR_FC_HI    = 5'h16;
    localparam logic [4:0] ADDR_RES_FILT = 5'h17;
    localparam logic [4:0] ADDR_MODE_VOL = 5'h18;
    localparam logic [4:0] ADDR_POT_X    = 5'h19;
    localparam logic [4:0] ADDR_POT_Y    = 5'h1A;
    localparam logic [4:0] ADDR_OSC3     = 5'h1B;
    localparam logic [4:0] ADDR_ENV3     = 5'h1C;

endpackage

// File: rtl/sid_voice_regs.sv
// Seven-byte register block for one voice; the parent qualifies the
// write strobe with address range and clk_en.
module sid_voice_regs
    import sid_pkg::*;
(
    input  logic        clk,
    input  logic        n_reset,
    input  logic        we,
    input  logic [2:0]  offset,
    input  logic [7:0]  data,
    output voice_regs_t regs
);

    // Byte-wise decode of the voice registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            regs <= '0;
        end else if (we) begin
            case (offset)
                OFF_FREQ_LO: regs.freq[7:0]  <= data;
                OFF_FREQ_HI: regs.freq[15:8] <= data;
                OFF_PW_LO:   regs.pw[7:0]    <= data;
                OFF_PW_HI:   regs.pw[11:8]   <= data[3:0];
                OFF_CTRL: begin
                    {regs.noise, regs.pulse, regs.saw, regs.triangle,
                     regs.test, regs.ring, regs.sync, regs.gate} <= data;
                end
                OFF_AD: begin
                    regs.atk <= data[7:4];
                    regs.dcy <= data[3:0];
                end
                OFF_SR: begin
                    regs.stn <= data[7:4];
                    regs.rls <= data[3:0];
                end
                default: regs <= regs;
            endcase
        end
    end

endmodule

// File: rtl/sid_regs.sv
// SID register file: three voice blocks, filter/volume registers,
// read-back mux and a decaying bus latch.
module sid_regs
    import sid_pkg::*;
#(
    parameter int DECAY_CYCLES = DECAY_CYCLES_DEF
) (
    input  logic                  clk,
    input  logic                  n_reset,
    input  logic                  clk_en,
    input  logic                  n_cs,
    input  logic                  r_nw,
    input  logic [4:0]            addr,
    input  logic [7:0]            data_in,
    output logic [7:0]            data_out,
    input  logic [7:0]            pot_x,
    input  logic [7:0]            pot_y,
    input  logic [7:0]            osc3,
    input  logic [7:0]            env3,
    output voice_regs_t [2:0]     voice_regs,
    output logic [10:0]           fc,
    output logic [3:0]            res,
    output logic [3:0]            filt,
    output logic [3:0]            mode,
    output logic [3:0]            vol
);

    localparam int         CW         = $clog2(DECAY_CYCLES + 1);
    localparam logic [CW-1:0] DECAY_MAX  = CW'(DECAY_CYCLES);
    localparam logic [CW-1:0] DECAY_LAST = CW'(DECAY_CYCLES - 1);

    logic          wr_access_s;
    logic          commit_s;
    logic          wr_prev_r;
    logic [7:0]    bus_latch_r;
    logic [CW-1:0] decay_cnt_r;
    logic [7:0]    rd_data_s;

    assign wr_access_s = ~n_cs & ~r_nw;
    // Only the first tick of a held write access commits.
    assign commit_s    = clk_en & wr_access_s & ~wr_prev_r;

    // Remember whether the previous sampled tick was a write access.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            wr_prev_r <= 1'b0;
        end else if (clk_en) begin
            wr_prev_r <= wr_access_s;
        end
    end

    genvar v;
    generate
        for (v = 0; v < 3; v++) begin : g_voice
            localparam logic [4:0] VBASE = 5'(VOICE_STRIDE * v);
            logic [4:0] rel_s;
            logic       hit_s;

            // Wrapping subtraction keeps the range test non-constant for voice 0.
            assign rel_s = addr - VBASE;
            assign hit_s = commit_s & (rel_s < 5'd7);

            sid_voice_regs u_voice (
                .clk     (clk),
                .n_reset (n_reset),
                .we      (hit_s),
                .offset  (rel_s[2:0]),
                .data    (data_in),
                .regs    (voice_regs[v])
            );
        end
    endgenerate

    // Filter and volume registers.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            fc   <= 11'd0;
            res  <= 4'd0;
            filt <= 4'd0;
            mode <= 4'd0;
            vol  <= 4'd0;
        end else if (commit_s) begin
            case (addr)
                ADDR_FC_LO: fc[2:0]  <= data_in[2:0];
                ADDR_FC_HI: fc[10:3] <= data_in;
                ADDR_RES_FILT: begin
                    res  <= data_in[7:4];
                    filt <= data_in[3:0];
                end
                ADDR_MODE_VOL: begin
                    mode <= data_in[7:4];
                    vol  <= data_in[3:0];
                end
                default: fc <= fc;
            endcase
        end
    end

    // Bus latch with decay; a commit wins over expiry on the same tick.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            bus_latch_r <= 8'h00;
            decay_cnt_r <= '0;
        end else if (commit_s) begin
            bus_latch_r <= data_in;
            decay_cnt_r <= '0;
        end else if (clk_en && (decay_cnt_r != DECAY_MAX)) begin
            decay_cnt_r <= decay_cnt_r + CW'(1);
            if (decay_cnt_r == DECAY_LAST) begin
                bus_latch_r <= 8'h00;
            end
        end
    end

    // Read-back source select.
    always_comb begin
        rd_data_s = bus_latch_r;
        case (addr)
            ADDR_POT_X: rd_data_s = pot_x;
            ADDR_POT_Y: rd_data_s = pot_y;
            ADDR_OSC3:  rd_data_s = osc3;
            ADDR_ENV3:  rd_data_s = env3;
            default:    rd_data_s = bus_latch_r;
        endcase
    end

    // Registered read data, held outside read ticks.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            data_out <= 8'h00;
        end else if (clk_en && !n_cs && r_nw) begin
            data_out <= rd_data_s;
        end
    end

endmodule

// File: tb/tb_sid_regs.sv
// Directed self-checking bench for sid_regs, built with a short decay
// period so latch expiry can be observed quickly.
module tb_sid_regs;
    import sid_pkg::*;

    logic              clk = 1'b0;
    logic              n_reset = 1'b0;
    logic              clk_en = 1'b1;
    logic              n_cs = 1'b1;
    logic              r_nw = 1'b1;
    logic [4:0]        addr = 5'h00;
    logic [7:0]        data_in = 8'h00;
    logic [7:0]        data_out;
    logic [7:0]        pot_x = 8'h11;
    logic [7:0]        pot_y = 8'h22;
    logic [7:0]        osc3 = 8'h5C;
    logic [7:0]        env3 = 8'h44;
    voice_regs_t [2:0] voice_regs;
    logic [10:0]       fc;
    logic [3:0]        res;
    logic [3:0]        filt;
    logic [3:0]        mode;
    logic [3:0]        vol;

    int n_cmp = 0;
    int n_err = 0;

    sid_regs #(.DECAY_CYCLES(4)) dut (
        .clk        (clk),
        .n_reset    (n_reset),
        .clk_en     (clk_en),
        .n_cs       (n_cs),
        .r_nw       (r_nw),
        .addr       (addr),
        .data_in    (data_in),
        .data_out   (data_out),
        .pot_x      (pot_x),
        .pot_y      (pot_y),
        .osc3       (osc3),
        .env3       (env3),
        .voice_regs (voice_regs),
        .fc         (fc),
        .res        (res),
        .filt       (filt),
        .mode       (mode),
        .vol        (vol)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [4:0] a, input logic [7:0] d);
        n_cs = 1'b0; r_nw = 1'b0; addr = a; data_in = d;
        tick();
        n_cs = 1'b1; r_nw = 1'b1;
        tick();
    endtask

    task automatic rd(input logic [4:0] a);
        n_cs = 1'b0; r_nw = 1'b1; addr = a;
        tick();
        n_cs = 1'b1;
    endtask

    function automatic logic [7:0] ctrl_of(input voice_regs_t r);
        return {r.noise, r.pulse, r.saw, r.triangle, r.test, r.ring, r.sync, r.gate};
    endfunction

    initial begin
        tick(); tick();
        chk("reset_data_out", 64'(data_out), 64'h0);
        chk("reset_voices", 64'(voice_regs[0] | voice_regs[1] | voice_regs[2]), 64'h0);
        chk("reset_filter", 64'({fc, res, filt, mode, vol}), 64'h0);
        n_reset = 1'b1;
        tick();

        // Voice 0 frequency
        wr(5'h00, 8'h34);
        wr(5'h01, 8'h12);
        chk("v0_freq", 64'(voice_regs[0].freq), 64'h1234);
        chk("v0_pw_untouched", 64'(voice_regs[0].pw), 64'h0);
        chk("v1_untouched", 64'(voice_regs[1]), 64'h0);
        chk("v2_untouched", 64'(voice_regs[2]), 64'h0);

        // Voice 2 control byte
        wr(5'h12, 8'h41);
        chk("v2_ctrl", 64'(ctrl_of(voice_regs[2])), 64'h41);
        chk("v2_pulse", 64'(voice_regs[2].pulse), 64'h1);
        chk("v2_freq_untouched", 64'(voice_regs[2].freq), 64'h0);

        // Held write commits exactly once
        n_cs = 1'b0; r_nw = 1'b0; addr = 5'h18; data_in = 8'h0F;
        tick();
        chk("hold_first_commit", 64'(vol), 64'hF);
        data_in = 8'h05;
        for (int i = 0; i < 9; i++) tick();
        chk("hold_vol", 64'(vol), 64'hF);
        chk("hold_mode", 64'(mode), 64'h0);
        n_cs = 1'b1; r_nw = 1'b1;
        tick();

        // Filter and voice 1 envelope/pulse width fields
        wr(5'h15, 8'hFF);
        wr(5'h16, 8'hAB);
        chk("fc", 64'(fc), 64'h55F);
        wr(5'h17, 8'hC3);
        chk("res_filt", 64'({res, filt}), 64'hC3);
        wr(5'h0A, 8'hF8);
        wr(5'h0C, 8'h27);
        wr(5'h0D, 8'h9E);
        chk("v1_pw", 64'(voice_regs[1].pw), 64'h800);
        chk("v1_adsr", 64'({voice_regs[1].atk, voice_regs[1].dcy, voice_regs[1].stn, voice_regs[1].rls}), 64'h279E);

        // Read back through bus latch and read-only sources
        wr(5'h05, 8'hA7);
        chk("v0_ad", 64'({voice_regs[0].atk, voice_regs[0].dcy}), 64'hA7);
        rd(5'h05);
        chk("rd_latch_05", 64'(data_out), 64'hA7);
        rd(5'h1B);
        chk("rd_osc3", 64'(data_out), 64'h5C);
        rd(5'h19);
        chk("rd_pot_x", 64'(data_out), 64'h11);
        rd(5'h1C);
        chk("rd_env3", 64'(data_out), 64'h44);

        // Writes above 0x18 only touch the bus latch
        wr(5'h1D, 8'h66);
        chk("ro_write_fc", 64'(fc), 64'h55F);
        chk("ro_write_vol", 64'({mode, vol}), 64'h0F);
        rd(5'h1D);
        chk("ro_write_latch", 64'(data_out), 64'h66);

        // Decay: commit tick + 3 ticks keeps data, the 4th clears it
        wr(5'h1F, 8'hFF);
        tick(); tick();
        rd(5'h00);
        chk("decay_3_ticks", 64'(data_out), 64'hFF);
        rd(5'h00);
        chk("decay_4_ticks", 64'(data_out), 64'h00);

        // Write landing on the expiry tick wins
        wr(5'h1E, 8'h5A);
        tick(); tick();
        wr(5'h1E, 8'hC3);
        rd(5'h00);
        chk("expiry_write_wins", 64'(data_out), 64'hC3);

        // clk_en low freezes reads and writes
        clk_en = 1'b0;
        n_cs = 1'b0; r_nw = 1'b1; addr = 5'h19;
        tick(); tick();
        chk("freeze_read", 64'(data_out), 64'hC3);
        r_nw = 1'b0; addr = 5'h18; data_in = 8'h07;
        tick(); tick(); tick();
        chk("freeze_write", 64'(vol), 64'hF);
        clk_en = 1'b1;
        tick();
        chk("unfreeze_commit", 64'({mode, vol}), 64'h07);
        n_cs = 1'b1; r_nw = 1'b1;
        tick();

        // Reset in the middle of a held write
        n_cs = 1'b0; r_nw = 1'b0; addr = 5'h00; data_in = 8'h99;
        n_reset = 1'b0;
        #1;
        chk("async_reset_vol", 64'(vol), 64'h0);
        chk("async_reset_v0", 64'(voice_regs[0]), 64'h0);
        chk("async_reset_data_out", 64'(data_out), 64'h0);
        tick(); tick();
        chk("held_in_reset", 64'(voice_regs[0].freq), 64'h0);
        n_reset = 1'b1;
        tick();
        chk("commit_after_reset", 64'(voice_regs[0].freq), 64'h0099);
        data_in = 8'h77;
        tick(); tick();
        chk("no_recommit_after_reset", 64'(voice_regs[0].freq), 64'h0099);
        n_cs = 1'b1; r_nw = 1'b1;
        tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
